// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcode codes, phase
// codes and the number of defined instructions.
package cpu_pkg;

  // Opcode values are fixed 4-bit codes regardless of the opcode field width.
  typedef enum logic [3:0] {
    OpLda = 4'd0,
    OpSta = 4'd1,
    OpAdd = 4'd2,
    OpSub = 4'd3,
    OpJmp = 4'd4,
    OpJmi = 4'd5,
    OpJeq = 4'd6,
    OpStp = 4'd7,
    OpLdi = 4'd8,
    OpLsl = 4'd9,
    OpLsr = 4'd10
  } opcode_e;

  // Encoding of the phase output and of the sequencer state register.
  typedef enum logic [1:0] {
    PhFetch = 2'd0,
    PhExec1 = 2'd1,
    PhExec2 = 2'd2,
    PhHalt  = 2'd3
  } phase_e;

  // Number of defined opcodes; also the width of the one-hot instruction vector.
  localparam int unsigned NumOps = 11;

endpackage

// File: rtl/cpu_op_decode.sv
// Instruction decoder: turns the latched opcode into a one-hot instruction
// vector indexed by opcode value, plus an illegal flag when no bit is set.
module cpu_op_decode
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0]    ir,
  output logic [NumOps-1:0] instr,
  output logic              illegal
);

  logic       upper_nz;
  logic [3:0] low;

  assign low = ir[3:0];

  // Any set bit above the 4-bit code makes the opcode illegal.
  if (OPW > 4) begin : gen_upper
    assign upper_nz = |ir[OPW-1:4];
  end else begin : gen_no_upper
    assign upper_nz = 1'b0;
  end

  // Decode the low nibble into one hot bit; codes 11..15 leave the vector empty.
  always_comb begin
    instr = '0;
    if (!upper_nz) begin
      case (low)
        OpLda:   instr[OpLda] = 1'b1;
        OpSta:   instr[OpSta] = 1'b1;
        OpAdd:   instr[OpAdd] = 1'b1;
        OpSub:   instr[OpSub] = 1'b1;
        OpJmp:   instr[OpJmp] = 1'b1;
        OpJmi:   instr[OpJmi] = 1'b1;
        OpJeq:   instr[OpJeq] = 1'b1;
        OpStp:   instr[OpStp] = 1'b1;
        OpLdi:   instr[OpLdi] = 1'b1;
        OpLsl:   instr[OpLsl] = 1'b1;
        OpLsr:   instr[OpLsr] = 1'b1;
        default: instr = '0;
      endcase
    end
  end

  assign illegal = ~|instr;

endmodule

// File: rtl/cpu_sequencer.sv
// Control sequencer for a small accumulator CPU. Walks FETCH -> EXEC1
// (-> EXEC2 for LDA) -> FETCH, stalls memory phases on mem_ready, halts on
// STP or an illegal opcode, and counts retired instructions with saturation.
// OPW must be at least 4.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPW       = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MEM_STALL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   op,
  input  logic             acc_neg,
  input  logic             acc_zero,
  input  logic             mem_ready,
  input  logic             run,
  output logic [1:0]       phase,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mem_wr,
  output logic             acc_load,
  output logic             addr_sel,
  output logic             acc_src,
  output logic             alu_add,
  output logic             shift_en,
  output logic             shift_right,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [1:0] StFetch = PhFetch;
  localparam logic [1:0] StExec1 = PhExec1;
  localparam logic [1:0] StExec2 = PhExec2;
  localparam logic [1:0] StHalt  = PhHalt;

  logic [1:0]        state_q, state_d;
  logic [OPW-1:0]    ir_q;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [NumOps-1:0] instr;
  logic              op_bad;
  logic              mem_rdy;
  logic              is_mem_op;
  logic              retire;

  // With stalling disabled every memory access is treated as completing at once.
  assign mem_rdy = (MEM_STALL != 0) ? mem_ready : 1'b1;

  cpu_op_decode #(
    .OPW(OPW)
  ) u_decode (
    .ir     (ir_q),
    .instr  (instr),
    .illegal(op_bad)
  );

  assign is_mem_op = instr[OpLda] | instr[OpSta] | instr[OpAdd] | instr[OpSub];

  // Next-state, sticky illegal flag and retire detection.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_rdy) state_d = StExec1;
      end
      StExec1: begin
        if (op_bad) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else if (instr[OpStp]) begin
          state_d = StHalt;
        end else if (is_mem_op && !mem_rdy) begin
          state_d = StExec1;
        end else if (instr[OpLda]) begin
          state_d = StExec2;
        end else begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec2: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt: begin
        if (run) begin
          state_d   = StFetch;
          illegal_d = 1'b0;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted so that a
  // pending mem_ready in the reset FETCH state cannot raise a fetch strobe.
  always_comb begin
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    mem_wr      = 1'b0;
    acc_load    = 1'b0;
    addr_sel    = 1'b0;
    acc_src     = 1'b0;
    alu_add     = 1'b0;
    shift_en    = 1'b0;
    shift_right = 1'b0;
    halted      = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          ir_load = mem_rdy;
          pc_inc  = mem_rdy;
        end
        StExec1: begin
          // Address mux points at the operand for the whole memory phase;
          // completion strobes wait for the access to finish.
          addr_sel = is_mem_op;
          if (instr[OpSta]) mem_wr = mem_rdy;
          if (instr[OpAdd]) begin
            acc_load = mem_rdy;
            alu_add  = mem_rdy;
          end
          if (instr[OpSub]) acc_load = mem_rdy;
          if (instr[OpLdi]) begin
            acc_src  = 1'b1;
            acc_load = 1'b1;
          end
          if (instr[OpJmp]) pc_load = 1'b1;
          if (instr[OpJmi]) pc_load = acc_neg;
          if (instr[OpJeq]) pc_load = acc_zero;
          if (instr[OpLsl] || instr[OpLsr]) begin
            shift_en = 1'b1;
            acc_load = 1'b1;
          end
          if (instr[OpLsr]) shift_right = 1'b1;
        end
        StExec2: begin
          acc_src  = 1'b1;
          acc_load = 1'b1;
        end
        StHalt: begin
          halted = 1'b1;
        end
        default: halted = 1'b0;
      endcase
    end
  end

  assign phase   = state_q;
  assign illegal = illegal_q;
  assign ret_cnt = cnt_q;

  // State and illegal flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Instruction register, loaded when a fetch completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else if (state_q == StFetch && mem_rdy) begin
      ir_q <= op;
    end
  end

  // Retired-instruction counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a table of per-cycle {inputs, expected outputs}
// rows is driven after each rising edge; the expected part goes into a
// scoreboard queue that a falling-edge checker pops and compares.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, acc_neg, acc_zero, mem_ready, run;
  logic [3:0] op;

  logic [1:0]  phase;
  logic        ir_load, pc_inc, pc_load, mem_wr, acc_load, addr_sel, acc_src;
  logic        alu_add, shift_en, shift_right, halted, illegal;
  logic [15:0] ret_cnt;

  logic [1:0]  s_phase;
  logic        s_ir_load, s_pc_inc, s_pc_load, s_mem_wr, s_acc_load, s_addr_sel;
  logic        s_acc_src, s_alu_add, s_shift_en, s_shift_right, s_halted, s_illegal;
  logic [1:0]  s_ret_cnt;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op(op), .acc_neg(acc_neg), .acc_zero(acc_zero),
    .mem_ready(mem_ready), .run(run), .phase(phase), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .mem_wr(mem_wr), .acc_load(acc_load),
    .addr_sel(addr_sel), .acc_src(acc_src), .alu_add(alu_add), .shift_en(shift_en),
    .shift_right(shift_right), .halted(halted), .illegal(illegal), .ret_cnt(ret_cnt)
  );

  // Narrow-counter instance for the saturation check; shares all inputs.
  cpu_sequencer #(
    .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .op(op), .acc_neg(acc_neg), .acc_zero(acc_zero),
    .mem_ready(mem_ready), .run(run), .phase(s_phase), .ir_load(s_ir_load),
    .pc_inc(s_pc_inc), .pc_load(s_pc_load), .mem_wr(s_mem_wr), .acc_load(s_acc_load),
    .addr_sel(s_addr_sel), .acc_src(s_acc_src), .alu_add(s_alu_add),
    .shift_en(s_shift_en), .shift_right(s_shift_right), .halted(s_halted),
    .illegal(s_illegal), .ret_cnt(s_ret_cnt)
  );

  // Output bit order: ir_load pc_inc pc_load mem_wr | acc_load addr_sel acc_src
  // alu_add | shift_en shift_right halted illegal
  logic [11:0] outs_act;
  assign outs_act = {ir_load, pc_inc, pc_load, mem_wr, acc_load, addr_sel, acc_src,
                     alu_add, shift_en, shift_right, halted, illegal};

  localparam logic [11:0] ONone = 12'b0000_0000_0000;
  localparam logic [11:0] OFtch = 12'b1100_0000_0000;
  localparam logic [11:0] OAddr = 12'b0000_0100_0000;
  localparam logic [11:0] OLdSr = 12'b0000_1010_0000;
  localparam logic [11:0] OSta  = 12'b0001_0100_0000;
  localparam logic [11:0] OPcl  = 12'b0010_0000_0000;
  localparam logic [11:0] OLsl  = 12'b0000_1000_1000;
  localparam logic [11:0] OLsr  = 12'b0000_1000_1100;
  localparam logic [11:0] OSub  = 12'b0000_1100_0000;
  localparam logic [11:0] OAdd  = 12'b0000_1101_0000;
  localparam logic [11:0] OHalt = 12'b0000_0000_0010;
  localparam logic [11:0] OHIll = 12'b0000_0000_0011;

  typedef struct {
    int          row;
    logic        rst_n;
    logic [3:0]  op;
    logic        neg;
    logic        zero;
    logic        mr;
    logic        run;
    logic [1:0]  ph;
    logic [11:0] outs;
    logic [15:0] cnt;
    logic        chk_sat;
    logic [1:0]  sat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur;
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] o, input logic n,
                              input logic z, input logic m, input logic ru,
                              input logic [1:0] ph, input logic [11:0] outs,
                              input logic [15:0] cnt, input logic cs,
                              input logic [1:0] sat);
    vec_t v;
    v.row = 0; v.rst_n = r; v.op = o; v.neg = n; v.zero = z; v.mr = m; v.run = ru;
    v.ph = ph; v.outs = outs; v.cnt = cnt; v.chk_sat = cs; v.sat = sat;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [15:0] got,
                     input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL row%0d %s: got %0h want %0h", row, name, got, want);
    end
  endtask

  // Scoreboard checker: compare one expected record per cycle, mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("phase", cur.row, {14'd0, phase}, {14'd0, cur.ph});
      chk("outs", cur.row, {4'd0, outs_act}, {4'd0, cur.outs});
      chk("ret_cnt", cur.row, ret_cnt, cur.cnt);
      if (cur.chk_sat) chk("sat_cnt", cur.row, {14'd0, s_ret_cnt}, {14'd0, cur.sat});
    end
  end

  initial begin
    rst_n = 1'b0; op = '0; acc_neg = 1'b0; acc_zero = 1'b0; mem_ready = 1'b0; run = 1'b0;

    // Reset held with mem_ready high: no strobes.
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, ONone, 0, 1, 0));
    // LDA with mem_ready always high: 0,1,2,0
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, OFtch, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OAddr, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 2, OLdSr, 0, 0, 0));
    // STA: fetch stalls once, then three EXEC1 stall cycles
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, ONone, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, OFtch, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, OAddr, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, OAddr, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, OAddr, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OSta, 1, 0, 0));
    // JMI not taken (mem_ready low is ignored), then taken
    vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, OFtch, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, ONone, 2, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, OFtch, 3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, OPcl, 3, 0, 0));
    // JEQ taken, LDI, LSL, LSR, SUB
    vecs.push_back(mk(1, 6, 0, 0, 1, 0, 0, OFtch, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, OPcl, 4, 0, 0));
    vecs.push_back(mk(1, 8, 0, 0, 1, 0, 0, OFtch, 5, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, OLdSr, 5, 0, 0));
    vecs.push_back(mk(1, 9, 0, 0, 1, 0, 0, OFtch, 6, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OLsl, 6, 0, 0));
    vecs.push_back(mk(1, 10, 0, 0, 1, 0, 0, OFtch, 7, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OLsr, 7, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 1, 0, 0, OFtch, 8, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OSub, 8, 0, 0));
    // ADD with one stall cycle
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 0, OFtch, 9, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, OAddr, 9, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OAdd, 9, 0, 0));
    // STP halts without retiring; run restarts
    vecs.push_back(mk(1, 7, 0, 0, 1, 0, 0, OFtch, 10, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, ONone, 10, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3, OHalt, 10, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3, OHalt, 10, 0, 0));
    // Illegal opcode 0xC
    vecs.push_back(mk(1, 12, 0, 0, 1, 0, 0, OFtch, 10, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, ONone, 10, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3, OHIll, 10, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3, OHIll, 10, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, ONone, 10, 0, 0));

    // Reset pulsed during LDA EXEC2, then first fetch right after release.
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, OFtch, 10, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OAddr, 10, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, ONone, 0, 1, 0));
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 0, OFtch, 0, 1, 0));
    // Five ADDs: narrow counter reads 1,2,3,3,3
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OAdd, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 0, OFtch, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OAdd, 1, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 0, OFtch, 2, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OAdd, 2, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 0, OFtch, 3, 1, 3));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OAdd, 3, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 1, 0, 0, OFtch, 4, 1, 3));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, OAdd, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, ONone, 5, 1, 3));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      cur = vecs[i];
      rst_n = cur.rst_n; op = cur.op; acc_neg = cur.neg; acc_zero = cur.zero;
      mem_ready = cur.mr; run = cur.run;
      cur.row = i;
      sb.push_back(cur);
    end
    @(posedge clk);
    @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 4, opcode width; values below 4 are illegal.
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have parameter MEM_STALL, default 1; 1 = honour mem_ready, 0 = treat mem_ready as constant 1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 op  in  OPW  opcode field of the memory data bus; sampled at FETCH completion.
REQ-007 acc_neg  in  1  accumulator sign flag.
REQ-008 acc_zero  in  1  accumulator zero flag.
REQ-009 mem_ready  in  1  memory access completes this cycle.
REQ-010 run  in  1  restart request while halted.
REQ-011 phase  out  2  current state: 0 FETCH, 1 EXEC1, 2 EXEC2, 3 HALT.
REQ-012 ir_load, pc_inc, pc_load, mem_wr, acc_load  out  1 each  single-cycle strobes.
REQ-013 addr_sel, acc_src, alu_add, shift_en, shift_right  out  1 each  level selects.
REQ-014 halted, illegal  out  1 each  status flags.
REQ-015 ret_cnt  out  CNT_W  retired-instruction count.

Function
REQ-016 Opcodes SHALL be: 0 LDA, 1 STA, 2 ADD, 3 SUB, 4 JMP, 5 JMI, 6 JEQ, 7 STP, 8 LDI, 9 LSL, 10 LSR; every other value, including any with nonzero bits above bit 3, is illegal.
REQ-017 FETCH: addr_sel=0; on mem_ready, ir_load=1, pc_inc=1, op latched into internal ir, next state EXEC1; otherwise the state is held and the strobes stay 0.
REQ-018 EXEC1, memory ops (LDA/STA/ADD/SUB): addr_sel=1 held until mem_ready; the completion strobes fire only in the mem_ready cycle.
REQ-019 EXEC1 completion: STA mem_wr=1; ADD acc_load=1, alu_add=1; SUB acc_load=1, alu_add=0; LDA none, next state EXEC2; all others then go to FETCH.
REQ-020 EXEC2 (LDA only): acc_src=1, acc_load=1 for one cycle, next state FETCH; no stall.
REQ-021 LDI EXEC1: acc_src=1, acc_load=1; no stall; next state FETCH.
REQ-022 JMP: pc_load=1; JMI: pc_load=acc_neg; JEQ: pc_load=acc_zero; flags sampled in EXEC1; no stall.
REQ-023 LSL: shift_en=1, shift_right=0, acc_load=1; LSR: shift_en=1, shift_right=1, acc_load=1.
REQ-024 STP in EXEC1 SHALL go to HALT; an illegal opcode in EXEC1 SHALL go to HALT and set illegal=1.
REQ-025 HALT: all strobes and selects 0, halted=1; run=1 -> FETCH next cycle and clear illegal; otherwise hold.
REQ-026 ret_cnt SHALL increment by 1 on each EXEC1->FETCH or EXEC2->FETCH transition and saturate at all-ones; STP and illegal opcodes do not count.
REQ-027 Outputs SHALL decode combinationally from the state register, the ir register, mem_ready and the flags; op SHALL have no effect outside FETCH.
REQ-028 mem_ready asserted in a non-stalling state SHALL be ignored.

Reset
REQ-029 While rst_n=0: state FETCH, ir 0, ret_cnt 0, illegal 0, halted 0, every strobe 0; assertion takes effect immediately, including mid-stall or mid-EXEC2.
REQ-030 First FETCH completion SHALL be possible on the first clk edge after rst_n rises with mem_ready=1.

Structure
REQ-031 Package cpu_pkg SHALL hold the opcode enum (OPW-independent 4-bit codes), the phase enum and the opcode count constant.
REQ-032 Sub-module cpu_op_decode SHALL map ir to a one-hot instruction vector plus an illegal bit; the FSM, ir and ret_cnt stay in cpu_sequencer.

Verification
REQ-033 Reset, then op=0 (LDA) with mem_ready=1 throughout -> phases 0,1,2,0; acc_load and acc_src high only in EXEC2; ret_cnt=1.
REQ-034 STA with mem_ready low for 3 EXEC1 cycles -> addr_sel=1 for 4 cycles, mem_wr=1 only in the 4th, no early strobe.
REQ-035 JMI with acc_neg=0, then with acc_neg=1 -> pc_load 0, then 1; both retire (ret_cnt +2).
REQ-036 op=0xC -> HALT, illegal=1, halted=1; run=1 -> FETCH next cycle, illegal=0.
REQ-037 CNT_W=2, five ADDs -> ret_cnt reads 1,2,3,3,3.
REQ-038 rst_n pulsed low during an LDA EXEC2 -> immediate FETCH with all strobes 0, ret_cnt=0.
